// File: rtl/mem_port_responder.sv
// ---------------------------------------------------------------------------
// mem_port_responder
//
// Memory-side end of the controller's memory handshake. It accepts one read or
// write request at a time and drives a synchronous single-port 32-bit SRAM
// macro. Reads return the selected 16-bit halfword. Writes store one halfword
// using byte enables.
//
// Parameters
//   ADDR_W        word address width of the SRAM (32-bit words)
//   READ_LATENCY  SRAM cycles from sampled CE to valid rdata (1..7)
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   read_en_in            read request, held until mem_output_valid_out
//   write_en_in           write request, held until mem_write_ready_out
//   addr_in               SRAM word address
//   word_select_in        0 = bits [15:0], 1 = bits [31:16]
//   write_data_in         halfword to store
//   sram_rdata_in         SRAM read data
//   sram_ce_out/we_out    SRAM chip / write enable (active-high)
//   sram_addr_out         SRAM address
//   sram_be_out           SRAM byte enables
//   sram_wdata_out        SRAM write data
//   read_data_out         halfword of the last completed read
//   mem_output_valid_out  one-cycle read completion pulse
//   mem_write_ready_out   one-cycle write completion pulse
//   busy_out              high whenever the FSM is not IDLE
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_port_responder #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en_in,
    input  logic              write_en_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              word_select_in,
    input  logic [15:0]       write_data_in,
    input  logic [31:0]       sram_rdata_in,
    output logic              sram_ce_out,
    output logic              sram_we_out,
    output logic [ADDR_W-1:0] sram_addr_out,
    output logic [3:0]        sram_be_out,
    output logic [31:0]       sram_wdata_out,
    output logic [15:0]       read_data_out,
    output logic              mem_output_valid_out,
    output logic              mem_write_ready_out,
    output logic              busy_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE,
        WR_ISSUE,
        WR_DONE
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              word_sel_q, word_sel_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ce_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        word_sel_d = word_sel_q;
        rdata_d    = rdata_q;
        valid_d    = 1'b0;
        ready_d    = 1'b0;

        case (state_q)
            // The completion states make the same accept decision as IDLE.
            // A request still held across the pulse therefore starts the
            // next access immediately (back-to-back).
            IDLE, RD_DONE, WR_DONE: begin
                if (write_en_in) begin
                    state_d = WR_ISSUE;
                    // One recovery cycle after the write strobe lets the macro
                    // commit before the completion pulse.
                    cnt_d   = 3'd1;
                    ce_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = addr_in;
                    be_d    = word_select_in ? 4'b1100 : 4'b0011;
                    wdata_d = {write_data_in, write_data_in};
                end else if (read_en_in) begin
                    state_d    = RD_ISSUE;
                    ce_d       = 1'b1;
                    addr_d     = addr_in;
                    be_d       = 4'b1111;
                    word_sel_d = word_select_in;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                // The SRAM samples CE on this exit edge. Data arrives
                // READ_LATENCY edges later, when the counter has run down to 0.
                state_d = RD_WAIT;
                cnt_d   = LAT_LOAD;
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = word_sel_q ? sram_rdata_in[31:16] : sram_rdata_in[15:0];
                    state_d = RD_DONE;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_ISSUE: begin
                if (cnt_q == 3'd0) begin
                    state_d = WR_DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            ce_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            word_sel_q <= 1'b0;
            rdata_q    <= 16'h0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ce_q       <= ce_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            word_sel_q <= word_sel_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign sram_ce_out          = ce_q;
    assign sram_we_out          = we_q;
    assign sram_addr_out        = addr_q;
    assign sram_be_out          = be_q;
    assign sram_wdata_out       = wdata_q;
    assign read_data_out        = rdata_q;
    assign mem_output_valid_out = valid_q;
    assign mem_write_ready_out  = ready_q;
    assign busy_out             = busy_q;

endmodule
